// File: rtl/led_pulse_stretch_pkg.sv
// rtl/led_pulse_stretch_pkg.sv - shared state encoding and Go Board timing constants
package led_pulse_stretch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  localparam int c_CLK_HZ      = 25_000_000;
  localparam int c_BLINK_DIV   = 10;
  // 100 ms at the board clock
  localparam int c_DEFAULT_LIM = c_CLK_HZ / c_BLINK_DIV;

endpackage

// File: rtl/led_pulse_stretch.sv
// rtl/led_pulse_stretch.sv - stretches single-cycle events into visible LED blinks with queueing
module led_pulse_stretch
  import led_pulse_stretch_pkg::*;
#(
  parameter int c_ON_LIMIT   = c_DEFAULT_LIM,
  parameter int c_OFF_LIMIT  = c_DEFAULT_LIM,
  parameter int c_CNT_WIDTH  = 22,
  parameter int c_PEND_WIDTH = 4
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic                    i_Event,
  input  logic                    i_Clear_Overflow,
  output logic                    o_LED,
  output logic                    o_Busy,
  output logic [c_PEND_WIDTH-1:0] o_Pending,
  output logic                    o_Overflow
);

  localparam logic [c_CNT_WIDTH-1:0]  c_ON_LAST  = c_CNT_WIDTH'(c_ON_LIMIT - 1);
  localparam logic [c_CNT_WIDTH-1:0]  c_OFF_LAST = c_CNT_WIDTH'(c_OFF_LIMIT - 1);
  localparam logic [c_PEND_WIDTH-1:0] c_PEND_MAX = '1;

  state_t                  r_state;
  logic [c_CNT_WIDTH-1:0]  r_cnt;
  logic [c_PEND_WIDTH-1:0] r_pend;
  logic                    r_led;
  logic                    r_busy;
  logic                    r_ovf;

  logic w_off_done;
  logic w_queue;
  logic w_drop;

  // The final OFF cycle consumes an event directly instead of queueing it
  assign w_off_done = (r_state == ST_OFF) && (r_cnt == c_OFF_LAST);
  assign w_queue    = i_Event && ((r_state == ST_ON) || ((r_state == ST_OFF) && !w_off_done));
  assign w_drop     = w_queue && (r_pend == c_PEND_MAX);

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_led   <= 1'b0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (i_Clear_Overflow) begin
        r_ovf <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          r_cnt  <= '0;
          r_pend <= '0;
          if (i_Event) begin
            r_state <= ST_ON;
            r_led   <= 1'b1;
            r_busy  <= 1'b1;
          end else begin
            r_led  <= 1'b0;
            r_busy <= 1'b0;
          end
        end

        ST_ON: begin
          if (w_queue && !w_drop) begin
            r_pend <= r_pend + 1'b1;
          end
          if (r_cnt == c_ON_LAST) begin
            r_state <= ST_OFF;
            r_cnt   <= '0;
            r_led   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            r_led <= 1'b1;
          end
          r_busy <= 1'b1;
        end

        ST_OFF: begin
          if (w_off_done) begin
            if (r_pend != '0) begin
              r_state <= ST_ON;
              r_cnt   <= '0;
              r_led   <= 1'b1;
              r_busy  <= 1'b1;
              // Decrement and a same-cycle event cancel out
              if (!i_Event) begin
                r_pend <= r_pend - 1'b1;
              end
            end else if (i_Event) begin
              r_state <= ST_ON;
              r_cnt   <= '0;
              r_led   <= 1'b1;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
              r_led   <= 1'b0;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_led  <= 1'b0;
            r_busy <= 1'b1;
            if (w_queue && !w_drop) begin
              r_pend <= r_pend + 1'b1;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_pend  <= '0;
          r_led   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_LED      = r_led;
  assign o_Busy     = r_busy;
  assign o_Pending  = r_pend;
  assign o_Overflow = r_ovf;

endmodule
